// File: rtl/ternary_dot_accumulator.sv
// ternary_dot_accumulator
//   Ternary-weight dot-product accumulator. Each input beat carries LANES
//   activations as a pos_a/neg_a pair plus a 2-bit ternary weight code per
//   lane. Each lane contributes +a, -a or 0. The lane terms are summed, and
//   the beat sums are accumulated over one vector of VEC_LEN elements. One
//   signed dot product is emitted per vector over a valid/ready handshake.
//
//   Build option: `define SAT_OUT_EN to clamp the final sum into the OUT_W
//   range. A clamp also raises out_err. Without the macro, out_data is the
//   low OUT_W bits of the final sum.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   input beat valid
//   in_ready   beat accepted when in_valid & in_ready
//   pos_a      LANES x signed 8-bit activations, lane i at [8i+7:8i]
//   neg_a      LANES x signed 8-bit negated activations
//   w_code     LANES x 2-bit codes: 01=+1, 11=-1, 00=0, 10=reserved
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts result
//   out_data   signed dot product, OUT_W bits
//   out_err    reserved code seen (or clamp applied); qualified by out_valid

module ternary_dot_accumulator #(
  parameter int LANES   = 16,
  parameter int VEC_LEN = 4096,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*8-1:0]    pos_a,
  input  logic [LANES*8-1:0]    neg_a,
  input  logic [LANES*2-1:0]    w_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_err
);

  localparam int BEATS = VEC_LEN / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {ACCUM = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic               drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               s1_valid_q, s1_valid_d;
  logic               s1_last_q, s1_last_d;
  logic [ACC_W-1:0]   s1_sum_q, s1_sum_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]   res_q, res_d;
  logic               err_q, err_d;
  logic               out_valid_q, out_valid_d;

  logic               xfer;
  logic               at_last;
  logic               out_hs;
  logic [9:0]         lane_term [LANES];
  logic [LANES-1:0]   lane_rsv;
  logic [ACC_W-1:0]   beat_sum;
  logic [ACC_W-1:0]   final_sum;
  logic [OUT_W-1:0]   final_out;
  logic               final_ovf;

  assign xfer    = in_valid & in_ready;
  assign at_last = (beat_cnt_q == LAST_BEAT);
  assign out_hs  = out_valid_q & out_ready;

  // Per-lane ternary select. Terms are 10 bits so that -(-128) is
  // representable as +128: neg_a wraps to -128 for that input, so the
  // magnitude is substituted directly.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] p;
    logic [7:0] n;
    logic [1:0] c;
    assign p = pos_a[8*gi +: 8];
    assign n = neg_a[8*gi +: 8];
    assign c = w_code[2*gi +: 2];
    assign lane_rsv[gi] = (c == 2'b10);

    always_comb begin
      lane_term[gi] = 10'd0;
      case (c)
        2'b01: lane_term[gi] = {{2{p[7]}}, p};
        2'b11: lane_term[gi] = (p == 8'h80) ? 10'd128 : {{2{n[7]}}, n};
        default: lane_term[gi] = 10'd0;
      endcase
    end
  end

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_sum = beat_sum + {{(ACC_W-10){lane_term[i][9]}}, lane_term[i]};
    end
  end

  // Stage 1: registered beat sum with valid/last tags; beat counter.
  always_comb begin
    s1_valid_d = xfer;
    s1_last_d  = xfer & at_last;
    s1_sum_d   = xfer ? beat_sum : s1_sum_q;
    beat_cnt_d = beat_cnt_q;
    if (xfer) beat_cnt_d = at_last ? '0 : beat_cnt_q + 1'b1;
  end

  // Final value presented to the result register on the last beat.
  assign final_sum = acc_q + s1_sum_q;

`ifdef SAT_OUT_EN
  // Bits above the OUT_W sign bit must all equal it, otherwise the value
  // lies outside the OUT_W range and is pinned to the nearest limit.
  logic [ACC_W-OUT_W:0] upper_bits;
  assign upper_bits = final_sum[ACC_W-1:OUT_W-1];
  assign final_ovf  = ~((&upper_bits) | (~|upper_bits));
  always_comb begin
    final_out = final_sum[OUT_W-1:0];
    if (final_ovf) begin
      final_out = final_sum[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                     : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  assign final_ovf = 1'b0;
  assign final_out = final_sum[OUT_W-1:0];
`endif

  // Stage 2: accumulate; on the last beat hand the total to the result
  // register and clear the accumulator for the next vector.
  always_comb begin
    acc_d = acc_q;
    res_d = res_q;
    err_d = err_q;
    if (s1_valid_q) begin
      if (s1_last_q) begin
        acc_d = '0;
        res_d = final_out;
        err_d = err_d | final_ovf;
      end else begin
        acc_d = final_sum;
      end
    end
    if (xfer && (|lane_rsv)) err_d = 1'b1;
    // Error flag belongs to the vector just delivered.
    if (state_q == DONE && out_hs) err_d = 1'b0;
  end

  // FSM next-state.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = 1'b0;
    case (state_q)
      ACCUM: if (xfer && at_last) state_d = DRAIN;
      DRAIN: begin
        drain_cnt_d = ~drain_cnt_q;
        if (drain_cnt_q) state_d = DONE;
      end
      DONE:  if (out_hs) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // FSM outputs. out_valid is registered, which places it exactly three
  // cycles after the final-beat handshake (two DRAIN cycles plus this flop).
  always_comb begin
    in_ready    = (state_q == ACCUM) & ~rst;
    out_valid_d = (state_q == DONE) & ~out_hs;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      drain_cnt_q <= 1'b0;
      beat_cnt_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_sum_q    <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_sum_q    <= s1_sum_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = res_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_ternary_dot_accumulator.sv
// Self-checking bench for ternary_dot_accumulator. Stimulus is randomized
// per vector; the expected dot product is computed with plain integer
// arithmetic (weight * activation summed over the vector).
module tb_ternary_dot_accumulator;
  localparam int LANES   = 16;
  localparam int VEC_LEN = 4096;
  localparam int ACC_W   = 32;
  localparam int OUT_W   = 24;
  localparam int BEATS   = VEC_LEN / LANES;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [LANES*8-1:0] pos_a;
  logic [LANES*8-1:0] neg_a;
  logic [LANES*2-1:0] w_code;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;
  logic               out_err;

  ternary_dot_accumulator #(
    .LANES(LANES), .VEC_LEN(VEC_LEN), .ACC_W(ACC_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pos_a(pos_a), .neg_a(neg_a), .w_code(w_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Modes: 0 all +1 w=01, 1 all -128 w=11, 2 random codes {00,01,11},
  // 3 random with reserved code on lane 3 of beat 7, 4 all +127 w=01,
  // 5 random activations with zero weights.
  task automatic drive_beat(input int mode, input int b, input bit gaps,
                            inout longint sum, inout bit err);
    int gap;
    gap = gaps ? (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0) : 0;
    repeat (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < LANES; i++) begin
      logic [7:0] p;
      logic [7:0] n;
      logic [1:0] c;
      int         w;
      case (mode)
        0: begin p = 8'd1;   c = 2'b01; end
        1: begin p = 8'h80;  c = 2'b11; end
        4: begin p = 8'd127; c = 2'b01; end
        5: begin p = 8'($urandom); c = 2'b00; end
        default: begin
          p = 8'($urandom);
          case ($urandom_range(0, 2))
            0: c = 2'b00;
            1: c = 2'b01;
            default: c = 2'b11;
          endcase
          if (mode == 3 && b == 7 && i == 3) c = 2'b10;
        end
      endcase
      n = 8'(0 - p);
      w = (c == 2'b01) ? 1 : (c == 2'b11) ? -1 : 0;
      if (c == 2'b10) err = 1'b1;
      sum += longint'(w) * longint'($signed(p));
      pos_a[8*i +: 8]  = p;
      neg_a[8*i +: 8]  = n;
      w_code[2*i +: 2] = c;
    end
    in_valid = 1'b1;
    check("in_ready_accum", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic finish_vector(input string name, input longint sum, input bit err_in);
    logic [ACC_W-1:0] acc_w;
    longint           a;
    longint           lim;
    bit               err;
    logic [OUT_W-1:0] exp_data;
    int               stall;
    err   = err_in;
    acc_w = sum[ACC_W-1:0];
    a     = longint'($signed(acc_w));
    lim   = longint'(1) <<< (OUT_W - 1);
`ifdef SAT_OUT_EN
    if (a > lim - 1) begin a = lim - 1; err = 1'b1; end
    if (a < -lim)    begin a = -lim;    err = 1'b1; end
`endif
    exp_data = a[OUT_W-1:0];
    // Final handshake edge has just passed.
    check({name, "_lat0"}, {31'd0, out_valid}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      check({name, "_drain_ready"}, {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      check({name, "_lat"}, {31'd0, out_valid}, (k == 3) ? 32'd1 : 32'd0);
    end
    stall = $urandom_range(0, 3);
    repeat (stall) begin
      check({name, "_data_hold"}, {{(32-OUT_W){1'b0}}, out_data}, {{(32-OUT_W){1'b0}}, exp_data});
      check({name, "_done_ready"}, {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      check({name, "_valid_hold"}, {31'd0, out_valid}, 32'd1);
    end
    check({name, "_data"}, {{(32-OUT_W){1'b0}}, out_data}, {{(32-OUT_W){1'b0}}, exp_data});
    check({name, "_err"}, {31'd0, out_err}, {31'd0, err});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({name, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_vector(input string name, input int mode, input bit gaps);
    longint sum;
    bit     err;
    sum = 0;
    err = 1'b0;
    for (int b = 0; b < BEATS; b++) drive_beat(mode, b, gaps, sum, err);
    finish_vector(name, sum, err);
  endtask

  initial begin
    longint dummy_sum;
    bit     dummy_err;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    pos_a = '0; neg_a = '0; w_code = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {{(32-OUT_W){1'b0}}, out_data}, 32'd0);
    check("rst_out_err",   {31'd0, out_err},   32'd0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    run_vector("ones",     0, 1'b0);
    run_vector("neg128",   1, 1'b0);
    run_vector("rand_a",   2, 1'b1);
    run_vector("rand_b",   2, 1'b1);
    run_vector("rand_c",   2, 1'b1);
    run_vector("rsv_beat7", 3, 1'b1);
    run_vector("clean",    2, 1'b1);
    run_vector("pos127",   4, 1'b0);

    // Partial vector carrying a reserved code, then reset mid-vector.
    dummy_sum = 0;
    dummy_err = 1'b0;
    for (int b = 0; b < 100; b++) drive_beat(3, b, 1'b1, dummy_sum, dummy_err);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_ready",     {31'd0, in_ready},  32'd1);
    @(negedge clk);
    run_vector("zero_after_rst", 5, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
